mc_alu_unit: RTL and testbench

Multi-cycle execute unit for the LEGv8 datapath: decodes `aluop`/`funct` into an ALU control code and executes the operation, adding iterative multiply and unsigned divide to the single-cycle ADD/SUB/AND/ORR/pass-B set. It sits in the EX stage of the multi-cycle processor. The control FSM stalls on `busy` and samples `result` when `done` pulses.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_op_dec.sv | 46 ++++
 rtl/mc_alu_unit.sv | 162 ++++++++++++++++
 tb/tb_mc_alu_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the LEGv8 multi-cycle execute unit: ALU control codes,
// R-type funct opcodes, aluop encodings and the control FSM state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b1000;
    localparam logic [3:0] ALU_UDIV  = 4'b1001;

    localparam logic [10:0] F_ADD  = 11'b10001011000;
    localparam logic [10:0] F_SUB  = 11'b11001011000;
    localparam logic [10:0] F_AND  = 11'b10001010000;
    localparam logic [10:0] F_ORR  = 11'b10101010000;
    localparam logic [10:0] F_MUL  = 11'b10011011000;
    localparam logic [10:0] F_UDIV = 11'b10011010110;

    localparam logic [1:0] AOP_MEM   = 2'b00;
    localparam logic [1:0] AOP_CBZ   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_op_dec.sv
// Combinational aluop/funct decoder for mc_alu_unit.
// UDIV is only recognised when MC_ALU_DIV_EN is defined; otherwise it decodes as illegal.
module alu_op_dec
    import alu_pkg::*;
(
    input  logic [1:0]  aluop,
    input  logic [10:0] funct,
    output logic [3:0]  alucontrol,
    output logic        is_mul,
    output logic        is_div,
    output logic        illegal
);

    always_comb begin
        alucontrol = ALU_AND;
        is_mul     = 1'b0;
        is_div     = 1'b0;
        illegal    = 1'b0;
        case (aluop)
            AOP_MEM: alucontrol = ALU_ADD;
            AOP_CBZ: alucontrol = ALU_PASSB;
            AOP_RTYPE: begin
                case (funct)
                    F_ADD: alucontrol = ALU_ADD;
                    F_SUB: alucontrol = ALU_SUB;
                    F_AND: alucontrol = ALU_AND;
                    F_ORR: alucontrol = ALU_ORR;
                    F_MUL: begin
                        alucontrol = ALU_MUL;
                        is_mul     = 1'b1;
                    end
`ifdef MC_ALU_DIV_EN
                    F_UDIV: begin
                        alucontrol = ALU_UDIV;
                        is_div     = 1'b1;
                    end
`endif
                    default: illegal = 1'b1;
                endcase
            end
            // aluop 11 is a legacy AND without the illegal flag
            default: alucontrol = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_alu_unit.sv
// Multi-cycle LEGv8 EX unit: single-cycle ADD/SUB/AND/ORR/pass-B, shift-add MUL
// and restoring UDIV. Define MC_ALU_DIV_EN to build the UDIV datapath and DIV state.
//
// state | meaning
// IDLE  | waiting for start
// MUL   | shift-add multiply, one multiplier bit per cycle, LSB first
// DIV   | restoring divide, one quotient bit per cycle, MSB first
// DONE  | result valid for this cycle; a new start is accepted here
module mc_alu_unit
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   aluop,
    input  logic [10:0]  funct,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [3:0]   alucontrol,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         busy,
    output logic         done,
    output logic         illegal
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [N-1:0]  opa, opb, acc;

    logic [3:0]    dec_ctrl;
    logic          dec_mul, dec_div, dec_ill;
    logic          accept, start_iter, last_iter;
    logic [N-1:0]  alu_out, sc_res, mul_nx;

    alu_op_dec u_dec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (dec_ctrl),
        .is_mul     (dec_mul),
        .is_div     (dec_div),
        .illegal    (dec_ill)
    );

    assign accept    = start && (state == ST_IDLE || state == ST_DONE);
    assign last_iter = (cnt == '0);
    assign mul_nx    = acc + (opb[0] ? opa : '0);

    always_comb begin
        alu_out = a & b;
        case (dec_ctrl)
            ALU_ADD:   alu_out = a + b;
            ALU_SUB:   alu_out = a - b;
            ALU_AND:   alu_out = a & b;
            ALU_ORR:   alu_out = a | b;
            ALU_PASSB: alu_out = b;
            default:   alu_out = a & b;
        endcase
    end

`ifdef MC_ALU_DIV_EN
    logic         b_zero, q_bit;
    logic [N:0]   rem_try, rem_sub;
    logic [N-1:0] rem_nx, quo_nx;

    // opa doubles as dividend shifter and quotient collector; acc is the partial remainder
    assign b_zero     = (b == '0);
    assign rem_try    = {acc, opa[N-1]};
    assign rem_sub    = rem_try - {1'b0, opb};
    assign q_bit      = ~rem_sub[N];
    assign rem_nx     = q_bit ? rem_sub[N-1:0] : rem_try[N-1:0];
    assign quo_nx     = {opa[N-2:0], q_bit};
    assign start_iter = dec_mul | (dec_div & ~b_zero);
    assign sc_res     = dec_div ? '1 : alu_out;
`else
    logic dec_div_unused;
    assign dec_div_unused = dec_div;
    assign start_iter     = dec_mul;
    assign sc_res         = alu_out;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (!start)
                    state_nx = ST_IDLE;
                else if (dec_mul)
                    state_nx = ST_MUL;
`ifdef MC_ALU_DIV_EN
                else if (dec_div && !b_zero)
                    state_nx = ST_DIV;
`endif
                else
                    state_nx = ST_DONE;
            end
            ST_MUL: if (last_iter) state_nx = ST_DONE;
`ifdef MC_ALU_DIV_EN
            ST_DIV: if (last_iter) state_nx = ST_DONE;
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_MUL) || (state == ST_DIV);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            opa        <= '0;
            opb        <= '0;
            acc        <= '0;
            alucontrol <= ALU_AND;
            result     <= '0;
            zero       <= 1'b1;
            illegal    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                alucontrol <= dec_ctrl;
                opa        <= a;
                opb        <= b;
                acc        <= '0;
                cnt        <= CW'(N - 1);
                if (!start_iter) begin
                    result  <= sc_res;
                    zero    <= (sc_res == '0);
                    illegal <= dec_ill;
                end
            end else if (state == ST_MUL) begin
                acc <= mul_nx;
                opa <= opa << 1;
                opb <= opb >> 1;
                cnt <= cnt - CW'(1);
                if (last_iter) begin
                    result  <= mul_nx;
                    zero    <= (mul_nx == '0);
                    illegal <= 1'b0;
                end
            end
`ifdef MC_ALU_DIV_EN
            else if (state == ST_DIV) begin
                acc <= rem_nx;
                opa <= quo_nx;
                cnt <= cnt - CW'(1);
                if (last_iter) begin
                    result  <= quo_nx;
                    zero    <= (quo_nx == '0);
                    illegal <= 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_mc_alu_unit.sv
// Self-checking bench for mc_alu_unit: directed cases with literal expectations
// plus randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mc_alu_unit;

    localparam int N = 64;

    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_AND  = 11'b10001010000;
    localparam logic [10:0] T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_MUL  = 11'b10011011000;
    localparam logic [10:0] T_UDIV = 11'b10011010110;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   aluop = 2'b00;
    logic [10:0]  funct = '0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [3:0]   alucontrol;
    logic [N-1:0] result;
    logic         zero, busy, done, illegal;

    mc_alu_unit #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .aluop      (aluop),
        .funct      (funct),
        .a          (a),
        .b          (b),
        .alucontrol (alucontrol),
        .result     (result),
        .zero       (zero),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;
    longint t_acc = 0;
    bit     chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (spec rules, plain arithmetic) ----------------
    // kind: 0 single-cycle, 1 multiply, 2 divide
    function automatic int m_kind(input logic [1:0] op, input logic [10:0] f);
        if (op != 2'b10) return 0;
        if (f == T_MUL) return 1;
`ifdef MC_ALU_DIV_EN
        if (f == T_UDIV) return 2;
`endif
        return 0;
    endfunction

    function automatic logic [3:0] m_ctrl_f(input logic [1:0] op, input logic [10:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0111;
        if (op == 2'b11) return 4'b0000;
        if (f == T_ADD) return 4'b0010;
        if (f == T_SUB) return 4'b0110;
        if (f == T_AND) return 4'b0000;
        if (f == T_ORR) return 4'b0001;
        if (f == T_MUL) return 4'b1000;
`ifdef MC_ALU_DIV_EN
        if (f == T_UDIV) return 4'b1001;
`endif
        return 4'b0000;
    endfunction

    function automatic logic m_ill_f(input logic [1:0] op, input logic [10:0] f);
        if (op != 2'b10) return 1'b0;
        if (f == T_ADD || f == T_SUB || f == T_AND || f == T_ORR || f == T_MUL) return 1'b0;
`ifdef MC_ALU_DIV_EN
        if (f == T_UDIV) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [N-1:0] m_single(input logic [1:0] op, input logic [10:0] f,
                                              input logic [N-1:0] x, input logic [N-1:0] y);
        if (m_kind(op, f) == 2) return '1;
        case (m_ctrl_f(op, f))
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0001: return x | y;
            4'b0111: return y;
            default: return x & y;
        endcase
    endfunction

    int           m_phase;   // 0 idle, 1 iterating, 2 result cycle
    int           m_left;
    logic [N-1:0] m_res, m_pend;
    logic         m_zero, m_ill;
    logic [3:0]   m_ctrl;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_left  <= 0;
            m_res   <= '0;
            m_zero  <= 1'b1;
            m_ill   <= 1'b0;
            m_ctrl  <= 4'b0000;
        end else if (start && m_phase != 1) begin
            m_ctrl <= m_ctrl_f(aluop, funct);
            if (m_kind(aluop, funct) == 1) begin
                m_phase <= 1;
                m_left  <= N;
                m_pend  <= a * b;
            end else if (m_kind(aluop, funct) == 2 && b != '0) begin
                m_phase <= 1;
                m_left  <= N;
                m_pend  <= a / b;
            end else begin
                m_phase <= 2;
                m_res   <= m_single(aluop, funct, a, b);
                m_zero  <= (m_single(aluop, funct, a, b) == '0);
                m_ill   <= m_ill_f(aluop, funct);
            end
        end else if (m_phase == 1) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_phase <= 2;
                m_res   <= m_pend;
                m_zero  <= (m_pend == '0);
                m_ill   <= 1'b0;
            end
        end else begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", N'(busy), N'(m_phase == 1));
            chk("done", N'(done), N'(m_phase == 2));
            chk("alucontrol", N'(alucontrol), N'(m_ctrl));
            chk("result", result, m_res);
            chk("zero", N'(zero), N'(m_zero));
            chk("illegal", N'(illegal), N'(m_ill));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic issue(input logic [1:0] op, input logic [10:0] f,
                         input logic [N-1:0] x, input logic [N-1:0] y);
        @(posedge clk); #1;
        start = 1'b1; aluop = op; funct = f; a = x; b = y;
        @(posedge clk); #1;
        t_acc = cyc;
        start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
    endtask

    task automatic wait_done(input int budget, output longint lat);
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - t_acc + 1;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", '0, N'(1));
    endtask

    task automatic run(input string nm, input logic [1:0] op, input logic [10:0] f,
                       input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [N-1:0] e_res, input logic e_zero, input logic e_ill,
                       input int e_lat);
        longint lat;
        issue(op, f, x, y);
        wait_done(e_lat + 10, lat);
        chk({nm, "_lat"}, N'(lat), N'(e_lat));
        chk({nm, "_res"}, result, e_res);
        chk({nm, "_zero"}, N'(zero), N'(e_zero));
        chk({nm, "_ill"}, N'(illegal), N'(e_ill));
    endtask

    function automatic logic [10:0] rnd_funct();
        case ($urandom % 8)
            0: return T_ADD;
            1: return T_SUB;
            2: return T_AND;
            3: return T_ORR;
            4: return T_MUL;
            5: return T_UDIV;
            default: return 11'($urandom);
        endcase
    endfunction

    function automatic logic [N-1:0] rnd_op();
        case ($urandom % 4)
            0: return '0;
            1: return N'($urandom % 256);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        longint lat;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_result", result, '0);
        chk("rst_zero", N'(zero), N'(1));
        chk("rst_ctrl", N'(alucontrol), N'(0));
        chk("rst_busy_done", N'({busy, done, illegal}), N'(0));
        @(posedge clk); #1 reset = 1'b0;

        run("add", 2'b10, T_ADD, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 1);
        run("sub", 2'b10, T_SUB, 64'd7, 64'd7, 64'd0, 1'b1, 1'b0, 1);

        // multiply with an ignored start part-way through the iteration
        issue(2'b10, T_MUL, 64'hFFFF_FFFF, 64'h1_0000_0001);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; aluop = 2'b10; funct = T_ADD; a = 64'd1; b = 64'd1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(100, lat);
        chk("mul_lat", N'(lat), N'(65));
        chk("mul_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mul_ctrl", N'(alucontrol), N'(4'b1000));

`ifdef MC_ALU_DIV_EN
        run("udiv", 2'b10, T_UDIV, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0, 65);
        run("udiv0", 2'b10, T_UDIV, 64'd9, 64'd0, '1, 1'b0, 1'b0, 1);
`else
        run("udiv", 2'b10, T_UDIV, 64'd100, 64'd7, 64'd4, 1'b0, 1'b1, 1);
        run("udiv0", 2'b10, T_UDIV, 64'd9, 64'd0, 64'd0, 1'b1, 1'b1, 1);
`endif

        run("illegal", 2'b10, 11'b11111111111, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b1, 1);
        run("cbz", 2'b01, 11'd0, 64'h1234, 64'd0, 64'd0, 1'b1, 1'b0, 1);
        run("ldur", 2'b00, 11'd0, 64'd100, 64'd28, 64'd128, 1'b0, 1'b0, 1);

        // reset part-way through a multiply
        issue(2'b10, T_MUL, 64'd3, 64'd5);
        repeat (29) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", N'(busy), N'(0));
        chk("rstmid_result", result, '0);
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (done) chk("rstmid_no_done", N'(done), N'(0));
        end
        run("orr", 2'b10, T_ORR, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 1);

        // back-to-back single-cycle ops
        @(posedge clk); #1;
        start = 1'b1; aluop = 2'b10; funct = T_ADD; a = 64'd10; b = 64'd20;
        @(posedge clk); #1;
        funct = T_AND; a = 64'hFF00; b = 64'h0FF0;
        @(negedge clk);
        chk("b2b_add", result, 64'd30);
        @(posedge clk); #1;
        funct = T_ORR; a = 64'h1; b = 64'h2;
        @(negedge clk);
        chk("b2b_and", result, 64'h0F00);
        chk("b2b_and_done", N'(done), N'(1));
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_orr", result, 64'h3);
        chk("b2b_orr_done", N'(done), N'(1));

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            reset = ($urandom % 600 == 0);
            start = ($urandom % 3 != 0);
            aluop = 2'($urandom);
            funct = rnd_funct();
            a     = rnd_op();
            b     = rnd_op();
        end
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (80) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
